scfifo_unpack_stream: RTL and testbench

- Downstream consumer of the show-ahead single-clock FIFO.
- Pops one wide word from the FIFO's q/empty/rdreq interface and serialises it into RATIO narrow beats on a valid/ready stream, least-significant slice first.
- Runs at full rate: a new word is loaded in the same cycle the last beat of the previous word is accepted, so back-to-back words produce no bubble.
- Keeps a word counter for status and debug.

---
 rtl/scfifo_unpack_stream.sv | 65 ++++++
 tb/tb_scfifo_unpack_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/scfifo_unpack_stream.sv
// scfifo_unpack_stream: pops wide show-ahead FIFO words and emits them as RATIO narrow valid/ready beats, LSB slice first.
module scfifo_unpack_stream #(
  parameter int IN_WIDTH  = 64,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH / RATIO,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 sclr,
  input  logic [IN_WIDTH-1:0]  fifo_q,
  input  logic                 fifo_empty,
  output logic                 fifo_rdreq,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count
);
  localparam int BW = $clog2(RATIO);

  if (RATIO < 2 || RATIO > 16 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("scfifo_unpack_stream: RATIO must be a power of two in 2..16");
  end
  if (IN_WIDTH % RATIO != 0 || OUT_WIDTH * RATIO != IN_WIDTH) begin : g_bad_width
    $error("scfifo_unpack_stream: IN_WIDTH must equal OUT_WIDTH*RATIO");
  end

  logic [IN_WIDTH-1:0]  word_q, word_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 xfer, load;

  assign out_valid  = valid_q;
  assign busy       = valid_q;
  assign out_data   = word_q[int'(beat_q) * OUT_WIDTH +: OUT_WIDTH];
  assign out_last   = valid_q & (beat_q == BW'(RATIO - 1));
  assign word_count = cnt_q;
  assign xfer       = out_valid & out_ready;
  // Reload in the same cycle the last beat leaves so back-to-back words have no bubble.
  assign load       = ~fifo_empty & (~valid_q | (xfer & out_last));
  assign fifo_rdreq = load & ~sclr;

  always_comb begin
    word_d  = load ? fifo_q : word_q;
    beat_d  = load ? '0 : xfer ? (out_last ? '0 : beat_q + BW'(1)) : beat_q;
    valid_d = load | (valid_q & ~(xfer & out_last));
    cnt_d   = cnt_q + CNT_WIDTH'(xfer & out_last);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      word_q  <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      word_q  <= word_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_scfifo_unpack_stream.sv
// tb_scfifo_unpack_stream: directed scenarios plus a random soak against a queue-based FIFO and beat scoreboard.
module tb_scfifo_unpack_stream;
  localparam int IW = 64, R = 4, OW = IW / R, CW = 32;

  logic          clock = 1'b0, sclr = 1'b1, fifo_empty = 1'b1, out_ready = 1'b0, gate = 1'b1;
  logic [IW-1:0] fifo_q = '0;
  logic          fifo_rdreq, out_valid, out_last, busy;
  logic [OW-1:0] out_data;
  logic [CW-1:0] word_count;

  scfifo_unpack_stream #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(CW)) dut (
    .clock(clock), .sclr(sclr), .fifo_q(fifo_q), .fifo_empty(fifo_empty), .fifo_rdreq(fifo_rdreq),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .word_count(word_count)
  );

  always #5 clock = ~clock;

  logic [IW-1:0] fq[$];
  logic [OW:0]   exp_q[$];
  int            n_chk = 0, n_pass = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          s_rd, s_ov, s_ol, s_busy;
  logic [OW-1:0] s_od;
  logic [CW-1:0] s_wc;
  logic          p_stall = 1'b0, p_ol = 1'b0;
  logic [OW-1:0] p_od = '0;

  task automatic refresh();
    fifo_empty = !(fq.size() > 0 && gate);
    fifo_q = fq.size() > 0 ? fq[0] : {$urandom, $urandom};
  endtask

  // One clock: sample at negedge, score accepted beats, then advance the FIFO/beat model at posedge.
  task automatic tick();
    logic [OW:0]   e;
    logic [IW-1:0] w;
    @(negedge clock);
    s_rd = fifo_rdreq; s_ov = out_valid; s_ol = out_last; s_od = out_data; s_busy = busy; s_wc = word_count;
    n_chk++; if (s_rd && fifo_empty) $display("FAIL underflow: rdreq got 1 with fifo_empty=1, exp 0"); else n_pass++;
    n_chk++; if (s_busy !== s_ov) $display("FAIL busy: got %b exp %b", s_busy, s_ov); else n_pass++;
    n_chk++; if (s_wc !== cnt_m) $display("FAIL word_count: got %0d exp %0d", s_wc, cnt_m); else n_pass++;
    if (p_stall) begin
      n_chk++;
      if (s_ov !== 1'b1 || s_od !== p_od || s_ol !== p_ol)
        $display("FAIL stall_hold: got v=%b d=%h l=%b exp v=1 d=%h l=%b", s_ov, s_od, s_ol, p_od, p_ol);
      else n_pass++;
    end
    if (s_ov && out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) $display("FAIL beat_order: got extra beat %h exp none", s_od);
      else begin
        e = exp_q.pop_front();
        if ({s_ol, s_od} !== e) $display("FAIL beat_order: got l=%b d=%h exp l=%b d=%h", s_ol, s_od, e[OW], e[OW-1:0]);
        else n_pass++;
      end
    end
    p_stall = s_ov && !out_ready && !sclr; p_od = s_od; p_ol = s_ol;
    @(posedge clock);
    if (sclr) begin
      exp_q.delete(); cnt_m = '0;
    end else begin
      if (s_ov && out_ready && s_ol) cnt_m++;
      if (s_rd) begin
        w = fq.pop_front();
        for (int i = 0; i < R; i++) exp_q.push_back({i == R - 1, w[i*OW +: OW]});
      end
    end
    #1 refresh();
  endtask

  task automatic drain();
    bit idle = 0;
    sclr = 1'b0; gate = 1'b1; out_ready = 1'b1; refresh();
    for (int i = 0; i < 200 && !idle; i++) begin
      tick();
      idle = fq.size() == 0 && !s_ov && exp_q.size() == 0;
    end
    n_chk++; if (!idle) $display("FAIL drain_timeout: got busy exp idle within 200 cycles"); else n_pass++;
  endtask

  task automatic test_reset();
    fq.push_back(64'h8888_7777_6666_5555); refresh();
    repeat (3) tick();
    n_chk++; if (s_rd !== 1'b0) $display("FAIL reset_rdreq: got %b exp 0", s_rd); else n_pass++;
    n_chk++; if (s_ov !== 1'b0 || s_ol !== 1'b0 || s_busy !== 1'b0)
      $display("FAIL reset_flags: got v=%b l=%b b=%b exp 0 0 0", s_ov, s_ol, s_busy); else n_pass++;
    n_chk++; if (s_wc !== '0 || s_od !== '0) $display("FAIL reset_regs: got wc=%0d d=%h exp 0 0", s_wc, s_od); else n_pass++;
    sclr = 1'b0;
    tick();
    n_chk++; if (s_rd !== 1'b1) $display("FAIL first_load: got rdreq %b exp 1", s_rd); else n_pass++;
    drain();
  endtask

  task automatic test_single();
    logic [CW-1:0] base = cnt_m;
    int pulses = 0;
    out_ready = 1'b1; fq.push_back(64'h4444_3333_2222_1111); refresh();
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(s_rd);
      if (i >= 1 && i <= 4) begin
        n_chk++;
        if (s_ov !== 1'b1 || s_od !== OW'(16'h1111 * i) || s_ol !== (i == 4))
          $display("FAIL single_beat%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, s_ov, s_od, s_ol, OW'(16'h1111 * i), i == 4);
        else n_pass++;
      end
    end
    n_chk++; if (s_ov !== 1'b0) $display("FAIL single_idle: got valid %b exp 0", s_ov); else n_pass++;
    n_chk++; if (pulses != 1) $display("FAIL single_pops: got %0d exp 1", pulses); else n_pass++;
    n_chk++; if (s_wc !== base + 1) $display("FAIL single_count: got %0d exp %0d", s_wc, base + 1); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [IW-1:0] w[3];
    logic [OW-1:0] e;
    logic [CW-1:0] base = cnt_m;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin w[k] = {$urandom, $urandom}; fq.push_back(w[k]); end
    refresh();
    for (int i = 0; i < 14; i++) begin
      tick();
      n_chk++; if (s_rd !== (i == 0 || i == 4 || i == 8)) $display("FAIL b2b_rdreq%0d: got %b exp %b", i, s_rd, i == 0 || i == 4 || i == 8); else n_pass++;
      if (i >= 1 && i <= 12) begin
        e = w[(i-1)/R][((i-1)%R)*OW +: OW];
        n_chk++;
        if (s_ov !== 1'b1 || s_od !== e || s_ol !== (i % R == 0))
          $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b exp v=1 d=%h l=%b", i, s_ov, s_od, s_ol, e, i % R == 0);
        else n_pass++;
      end
    end
    n_chk++; if (s_ov !== 1'b0) $display("FAIL b2b_idle: got valid %b exp 0", s_ov); else n_pass++;
    n_chk++; if (s_wc !== base + 3) $display("FAIL b2b_count: got %0d exp %0d", s_wc, base + 3); else n_pass++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    fq.push_back(64'h4444_3333_2222_1111); fq.push_back({$urandom, $urandom}); refresh();
    repeat (3) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (s_ov !== 1'b1 || s_od !== 16'h3333 || s_rd !== 1'b0)
        $display("FAIL bp_stall%0d: got v=%b d=%h rd=%b exp v=1 d=3333 rd=0", i, s_ov, s_od, s_rd);
      else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_chk++; if (s_od !== 16'h3333 || s_ol !== 1'b0) $display("FAIL bp_resume: got d=%h l=%b exp 3333 0", s_od, s_ol); else n_pass++;
    tick();
    n_chk++; if (s_od !== 16'h4444 || s_ol !== 1'b1 || s_rd !== 1'b1)
      $display("FAIL bp_last: got d=%h l=%b rd=%b exp 4444 1 1", s_od, s_ol, s_rd); else n_pass++;
    drain();
  endtask

  task automatic test_drain();
    logic [IW-1:0] w = {$urandom, $urandom}, w2 = {$urandom, $urandom};
    out_ready = 1'b1; fq.push_back(w); refresh();
    repeat (5) tick();
    n_chk++; if (s_ol !== 1'b1 || s_rd !== 1'b0) $display("FAIL drain_last: got l=%b rd=%b exp 1 0", s_ol, s_rd); else n_pass++;
    tick();
    n_chk++; if (s_ov !== 1'b0 || s_rd !== 1'b0) $display("FAIL drain_empty: got v=%b rd=%b exp 0 0", s_ov, s_rd); else n_pass++;
    repeat (2) tick();
    fq.push_back(w2); refresh();
    tick();
    n_chk++; if (s_rd !== 1'b1 || s_ov !== 1'b0) $display("FAIL drain_arrive: got rd=%b v=%b exp 1 0", s_rd, s_ov); else n_pass++;
    tick();
    n_chk++; if (s_ov !== 1'b1 || s_od !== w2[OW-1:0]) $display("FAIL drain_latency: got v=%b d=%h exp 1 %h", s_ov, s_od, w2[OW-1:0]); else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] w2 = {$urandom, $urandom};
    out_ready = 1'b1; fq.push_back({$urandom, $urandom}); fq.push_back(w2); refresh();
    repeat (3) tick();
    sclr = 1'b1;
    tick();
    n_chk++; if (s_rd !== 1'b0) $display("FAIL rst_mid_rd: got %b exp 0", s_rd); else n_pass++;
    tick();
    n_chk++; if (s_ov !== 1'b0 || s_wc !== '0 || s_rd !== 1'b0)
      $display("FAIL rst_mid_clear: got v=%b wc=%0d rd=%b exp 0 0 0", s_ov, s_wc, s_rd); else n_pass++;
    sclr = 1'b0;
    tick();
    n_chk++; if (s_rd !== 1'b1) $display("FAIL rst_mid_reload: got rd %b exp 1", s_rd); else n_pass++;
    tick();
    n_chk++; if (s_ov !== 1'b1 || s_od !== w2[OW-1:0] || s_ol !== 1'b0)
      $display("FAIL rst_mid_beat0: got v=%b d=%h l=%b exp 1 %h 0", s_ov, s_od, s_ol, w2[OW-1:0]); else n_pass++;
    drain();
  endtask

  task automatic test_random_soak();
    for (int i = 0; i < 10000; i++) begin
      if (fq.size() < 6 && $urandom_range(0, 2) == 0) fq.push_back({$urandom, $urandom});
      gate = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      sclr = $urandom_range(0, 499) == 0;
      refresh();
      tick();
    end
    drain();
    n_chk++; if (exp_q.size() != 0) $display("FAIL soak_leftover: got %0d beats exp 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    refresh();
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random_soak();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
